// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and colour definitions.
package vga_pkg;

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned COLOR_W       = 12;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;
    localparam int unsigned CLK_DIV_DEF   = 4;

    // {R[3:0], G[3:0], B[3:0]}
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t COLOR_BLACK = 12'h000;
    localparam color_t COLOR_WHITE = 12'hFFF;

endpackage : vga_pkg

// File: rtl/vga_scan_gen_pixel_tick_div.sv
// Divides the system clock down to a one-clock pixel tick every CLK_DIV clocks.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             w_last;

    assign w_last = (r_div == DIV_W'(CLK_DIV - 1));

    // Free-running divider, 0..CLK_DIV-1, restarts from 0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Tick on the last clock of each pixel period; r_div is 0 in reset so this is low.
    assign p_tick = w_last;

endmodule : pixel_tick_div

// File: rtl/vga_scan_gen.sv
// VGA scan generator: pixel counters, sync decode and registered connector outputs.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,   // must be >= 2
    parameter color_t      FG_COLOR  = COLOR_WHITE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               display,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               p_tick,
    output logic               video_on,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb
);

    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_LO = H_DISPLAY + H_FP;
    localparam int unsigned H_SYNC_HI = H_DISPLAY + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_DISPLAY + V_FP;
    localparam int unsigned V_SYNC_HI = V_DISPLAY + V_FP + V_SYNC;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hsync;
    logic             r_vsync;
    color_t           r_rgb;

    logic             w_p_tick;
    logic             w_h_end;
    logic             w_v_end;
    logic             w_video_on;
    logic             w_h_sync_n;
    logic             w_v_sync_n;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (w_p_tick)
    );

    assign w_h_end    = (r_h == CNT_W'(H_TOTAL - 1));
    assign w_v_end    = (r_v == CNT_W'(V_TOTAL - 1));
    assign w_video_on = (r_h < CNT_W'(H_DISPLAY)) && (r_v < CNT_W'(V_DISPLAY));
    assign w_h_sync_n = !((r_h >= CNT_W'(H_SYNC_LO)) && (r_h < CNT_W'(H_SYNC_HI)));
    assign w_v_sync_n = !((r_v >= CNT_W'(V_SYNC_LO)) && (r_v < CNT_W'(V_SYNC_HI)));

    // Horizontal/vertical position counters, advanced once per pixel tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_p_tick) begin
            if (w_h_end) begin
                r_h <= '0;
                r_v <= w_v_end ? '0 : r_v + CNT_W'(1);
            end else begin
                r_h <= r_h + CNT_W'(1);
            end
        end
    end

    // Connector registers capture the current pixel on its tick so all three stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= COLOR_BLACK;
        end else if (w_p_tick) begin
            r_hsync <= w_h_sync_n;
            r_vsync <= w_v_sync_n;
            r_rgb   <= (w_video_on && display) ? FG_COLOR : COLOR_BLACK;
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign p_tick      = w_p_tick;
    assign video_on    = w_video_on;
    assign frame_start = w_p_tick && (r_h == '0) && (r_v == '0);
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;

endmodule : vga_scan_gen

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen using a reduced raster so several frames fit the run.
module tb_vga_scan_gen;

    localparam int unsigned HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VD = 8,  VF = 2, VS = 2, VB = 3;
    localparam int unsigned CD = 4;
    localparam int unsigned HT = HD + HF + HS + HB;   // 24
    localparam int unsigned VT = VD + VF + VS + VB;   // 15
    localparam int unsigned FRAME = HT * VT;          // 360 pixels

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        display = 1'b0;
    logic [9:0]  x, y;
    logic        p_tick, video_on, frame_start, hsync, vsync;
    logic [11:0] rgb;

    vga_scan_gen #(
        .H_DISPLAY (HD), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_DISPLAY (VD), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV   (CD), .FG_COLOR (12'hFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .display     (display),
        .x           (x),
        .y           (y),
        .p_tick      (p_tick),
        .video_on    (video_on),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned n_pix = 0;      // pixel ticks since reset, the reference position
    int unsigned mx = 0, my = 0; // reference coordinates of the current pixel
    longint      cyc = 0;
    longint      last_fs = -1;
    int          fff_cnt = 0;
    logic        last_tick = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (pixel %0d,%0d t=%0t)", name, act, exp, mx, my, $time);
        end
    endtask

    // Reference: what the connector should show for a pixel, from raster geometry alone.
    function automatic exp_t model_out(input int unsigned px, input int unsigned py, input logic d);
        exp_t e;
        e.hs  = !(px >= HD + HF && px < HD + HF + HS);
        e.vs  = !(py >= VD + VF && py < VD + VF + VS);
        e.rgb = (px < HD && py < VD && d) ? 12'hFFF : 12'h000;
        return e;
    endfunction

    // One system clock: drive display, check the coordinate side, push expected outputs.
    // mode 0: random per pixel, 1: always on, 2: only at pixel (5,3)
    task automatic step(input int mode);
        @(negedge clk);
        cyc++;
        mx = n_pix % HT;
        my = (n_pix / HT) % VT;
        case (mode)
            0:       if (last_tick) display = 1'($urandom_range(0, 1));
            1:       display = 1'b1;
            default: display = (mx == 5 && my == 3);
        endcase
        last_tick = p_tick;
        if (p_tick) begin
            check("x", x, mx);
            check("y", y, my);
            check("video_on", video_on, (mx < HD && my < VD));
            check("frame_start", frame_start, (mx == 0 && my == 0));
            if (frame_start) begin
                if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME * CD);
                last_fs = cyc;
            end
            q.push_back(model_out(mx, my, display));
            n_pix++;
        end else if (frame_start) begin
            check("frame_start_idle", frame_start, 0);
        end
    endtask

    // Hold reset for a number of edges, check reset values, then time the first tick.
    task automatic do_reset(input int clocks);
        int k;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        repeat (clocks) @(negedge clk);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_rgb", rgb, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_p_tick", p_tick, 0);
        check("rst_frame_start", frame_start, 0);
        reset     = 1'b0;
        n_pix     = 0;
        last_fs   = -1;
        last_tick = 1'b0;
        k = 0;
        do begin
            step(0);
            k++;
        end while (!last_tick && k < 20);
        // p_tick is high during the CLK_DIV-th clock after release
        check("first_tick", k, CD - 1);
    endtask

    // Count on-pixels across exactly one frame, starting at a frame boundary.
    task automatic run_frame_count(input int mode, input int exp_cnt, input string name);
        int unsigned start;
        int guard;
        guard = 0;
        while (!(last_tick && (n_pix % FRAME) == 0) && guard < FRAME * CD + 10) begin
            step(0);
            guard++;
        end
        check({name, "_align"}, (n_pix % FRAME), 0);
        fff_cnt = 0;
        start   = n_pix;
        guard   = 0;
        while (n_pix < start + FRAME && guard < FRAME * CD + 10) begin
            step(mode);
            guard++;
        end
        step(mode);
        step(mode);
        check(name, fff_cnt, exp_cnt);
    endtask

    // Monitor: after every tick edge the registered outputs must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        if (last_tick && !reset) begin
            #1;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: got output with no expectation at t=%0t", $time);
            end else begin
                e = q.pop_front();
                check("hsync", hsync, e.hs);
                check("vsync", vsync, e.vs);
                check("rgb", rgb, e.rgb);
                if (rgb == 12'hFFF) fff_cnt++;
            end
        end
    end

    initial begin
        int guard;
        bit found;
        do_reset(10);

        repeat (2 * FRAME * CD) step(0);

        run_frame_count(1, HD * VD, "all_on_count");
        run_frame_count(2, 1, "single_pixel_count");

        // Reset mid-frame inside the vertical sync window
        found = 1'b0;
        guard = 0;
        while (!found && guard < 2 * FRAME * CD) begin
            step(0);
            guard++;
            if (last_tick && mx == HD + HF && my == VD + VF + 1) found = 1'b1;
        end
        check("midframe_found", found, 1);
        check("vsync_before_reset", vsync, 0);
        do_reset(1);

        guard = 0;
        while (n_pix < FRAME + 2 && guard < 2 * FRAME * CD) begin
            step(0);
            guard++;
        end
        check("post_reset_frame", (n_pix >= FRAME + 2), 1);
        step(0);
        step(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_vga_scan_gen
